// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned PC_SEL_W   = 2;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_ENTER = 2'd2
    } pipe_state_e;

    // PC source select encodings
    localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_BR   = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_TRAP = 2'b10;
    localparam logic [PC_SEL_W-1:0] PC_SEL_MEPC = 2'b11;

    // Per-register stall/flush controls produced by the sequencer
    typedef struct packed {
        logic stall_pc;
        logic stall_rb1;
        logic stall_rb2;
        logic flush_rb1;
        logic flush_rb2;
    } pipe_ctl_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Core-side hazard/redirect/memory signals and sequencer controls.
interface pipe_ctrl_unit_if #(
    parameter int unsigned CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] dec_rs1_addr_in;
    logic [REG_ADDR_W-1:0] dec_rs2_addr_in;
    logic                  dec_rs1_used_in;
    logic                  dec_rs2_used_in;
    logic [REG_ADDR_W-1:0] ex_rd_addr_in;
    logic                  ex_rf_wr_en_in;
    logic                  ex_is_load_in;
    logic                  branch_taken_in;
    logic                  trap_req_in;
    logic                  mret_in;
    logic                  dmem_req_in;
    logic                  dmem_ack_in;

    logic                  stall_pc_out;
    logic                  stall_rb1_out;
    logic                  stall_rb2_out;
    logic                  flush_rb1_out;
    logic                  flush_rb2_out;
    logic [PC_SEL_W-1:0]   pc_sel_out;
    logic                  bus_err_out;
    logic [CNT_W-1:0]      stall_cycles_out;

    // Core side: drives pipeline status, consumes sequencer controls
    modport master (
        output dec_rs1_addr_in, dec_rs2_addr_in, dec_rs1_used_in, dec_rs2_used_in,
        output ex_rd_addr_in, ex_rf_wr_en_in, ex_is_load_in,
        output branch_taken_in, trap_req_in, mret_in, dmem_req_in, dmem_ack_in,
        input  stall_pc_out, stall_rb1_out, stall_rb2_out,
        input  flush_rb1_out, flush_rb2_out, pc_sel_out, bus_err_out, stall_cycles_out
    );

    // Sequencer side
    modport slave (
        input  dec_rs1_addr_in, dec_rs2_addr_in, dec_rs1_used_in, dec_rs2_used_in,
        input  ex_rd_addr_in, ex_rf_wr_en_in, ex_is_load_in,
        input  branch_taken_in, trap_req_in, mret_in, dmem_req_in, dmem_ack_in,
        output stall_pc_out, stall_rb1_out, stall_rb2_out,
        output flush_rb1_out, flush_rb2_out, pc_sel_out, bus_err_out, stall_cycles_out
    );

endinterface

// File: rtl/pipe_ctrl_unit_hazard_detect.sv
// Load-use hazard detection between the decode instruction and a load in stage 2.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rf_wr_en,
    input  logic                  is_load,
    output logic                  load_use_c
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired zero, so a load targeting it never produces a dependency
    always_comb begin
        rd_live    = is_load && rf_wr_en && (rd_addr != REG_ADDR_W'(0));
        rs1_hit    = rs1_used && (rs1_addr == rd_addr);
        rs2_hit    = rs2_used && (rs2_addr == rd_addr);
        load_use_c = rd_live && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencer: stalls, flushes and PC redirects for the two stage registers,
// memory-wait freeze with timeout, and a saturating stall-cycle counter.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    pipe_ctrl_unit_if.slave  bus
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    pipe_state_e         state_q, state_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                trap_pend_q, trap_pend_d;
    logic                bus_err_q, bus_err_d;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic                load_use_c;
    pipe_ctl_t           raw_c;
    pipe_ctl_t           ctl_c;
    logic [PC_SEL_W-1:0] pc_sel_c;

    hazard_detect u_hazard (
        .rs1_addr   (bus.dec_rs1_addr_in),
        .rs2_addr   (bus.dec_rs2_addr_in),
        .rs1_used   (bus.dec_rs1_used_in),
        .rs2_used   (bus.dec_rs2_used_in),
        .rd_addr    (bus.ex_rd_addr_in),
        .rf_wr_en   (bus.ex_rf_wr_en_in),
        .is_load    (bus.ex_is_load_in),
        .load_use_c (load_use_c)
    );

    // Next-state, timeout, pending-trap and raw control decode
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        trap_pend_d = trap_pend_q;
        bus_err_d   = 1'b0;
        raw_c       = '0;
        pc_sel_c    = PC_SEL_SEQ;

        unique case (state_q)
            RUN: begin
                if (bus.trap_req_in) begin
                    raw_c.flush_rb1 = 1'b1;
                    raw_c.flush_rb2 = 1'b1;
                    pc_sel_c        = PC_SEL_TRAP;
                    state_d         = TRAP_ENTER;
                end else if (bus.mret_in) begin
                    raw_c.flush_rb1 = 1'b1;
                    pc_sel_c        = PC_SEL_MEPC;
                end else if (bus.branch_taken_in) begin
                    // the branch itself sits in stage 2 and must retire
                    raw_c.flush_rb1 = 1'b1;
                    pc_sel_c        = PC_SEL_BR;
                end else if (bus.dmem_req_in && !bus.dmem_ack_in) begin
                    raw_c.stall_pc  = 1'b1;
                    raw_c.stall_rb1 = 1'b1;
                    raw_c.stall_rb2 = 1'b1;
                    tmo_cnt_d       = TMO_W'(1);
                    state_d         = MEM_WAIT;
                end else if (load_use_c) begin
                    // hold fetch/decode, insert a bubble into execute
                    raw_c.stall_pc  = 1'b1;
                    raw_c.stall_rb1 = 1'b1;
                    raw_c.flush_rb2 = 1'b1;
                end
            end

            MEM_WAIT: begin
                raw_c.stall_pc  = 1'b1;
                raw_c.stall_rb1 = 1'b1;
                raw_c.stall_rb2 = 1'b1;
                if (bus.trap_req_in) begin
                    trap_pend_d = 1'b1;
                end
                if (bus.dmem_ack_in) begin
                    tmo_cnt_d = '0;
                    state_d   = (trap_pend_q || bus.trap_req_in) ? TRAP_ENTER : RUN;
                end else if (tmo_cnt_q >= TMO_W'(MEM_TIMEOUT)) begin
                    tmo_cnt_d = '0;
                    bus_err_d = 1'b1;
                    state_d   = TRAP_ENTER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            TRAP_ENTER: begin
                // a still-asserted trap request is already being serviced
                raw_c.flush_rb1 = 1'b1;
                raw_c.flush_rb2 = 1'b1;
                pc_sel_c        = PC_SEL_TRAP;
                trap_pend_d     = 1'b0;
                state_d         = RUN;
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Flush overrides stall on the same register
    always_comb begin
        ctl_c           = raw_c;
        ctl_c.stall_rb1 = raw_c.stall_rb1 && !raw_c.flush_rb1;
        ctl_c.stall_rb2 = raw_c.stall_rb2 && !raw_c.flush_rb2;
    end

    // Sequencer state, timeout counter, pending trap and bus-error pulse
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= RUN;
            tmo_cnt_q   <= '0;
            trap_pend_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            trap_pend_q <= trap_pend_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Saturating count of PC-stall cycles
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt_q <= '0;
        end else if (ctl_c.stall_pc && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_pc_out     = ctl_c.stall_pc;
    assign bus.stall_rb1_out    = ctl_c.stall_rb1;
    assign bus.stall_rb2_out    = ctl_c.stall_rb2;
    assign bus.flush_rb1_out    = ctl_c.flush_rb1;
    assign bus.flush_rb2_out    = ctl_c.flush_rb2;
    assign bus.pc_sel_out       = pc_sel_c;
    assign bus.bus_err_out      = bus_err_q;
    assign bus.stall_cycles_out = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (MEM_TIMEOUT=4, CNT_W=3).
module tb_pipe_ctrl_unit;

    localparam int unsigned TB_TMO   = 4;
    localparam int unsigned TB_CNT_W = 3;

    // Control vector order: {stall_pc, stall_rb1, stall_rb2, flush_rb1, flush_rb2, pc_sel[1:0]}
    localparam logic [6:0] V_IDLE = 7'b00000_00;
    localparam logic [6:0] V_LU   = 7'b11001_00;
    localparam logic [6:0] V_BR   = 7'b00010_01;
    localparam logic [6:0] V_MEPC = 7'b00010_11;
    localparam logic [6:0] V_TRAP = 7'b00011_10;
    localparam logic [6:0] V_MEM  = 7'b11100_00;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pipe_ctrl_unit_if #(.CNT_W(TB_CNT_W)) bus ();

    pipe_ctrl_unit #(
        .MEM_TIMEOUT (TB_TMO),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {bus.stall_pc_out, bus.stall_rb1_out, bus.stall_rb2_out,
                bus.flush_rb1_out, bus.flush_rb2_out, bus.pc_sel_out};
    endfunction

    task automatic idle_inputs();
        bus.dec_rs1_addr_in = '0;
        bus.dec_rs2_addr_in = '0;
        bus.dec_rs1_used_in = 1'b0;
        bus.dec_rs2_used_in = 1'b0;
        bus.ex_rd_addr_in   = '0;
        bus.ex_rf_wr_en_in  = 1'b0;
        bus.ex_is_load_in   = 1'b0;
        bus.branch_taken_in = 1'b0;
        bus.trap_req_in     = 1'b0;
        bus.mret_in         = 1'b0;
        bus.dmem_req_in     = 1'b0;
        bus.dmem_ack_in     = 1'b0;
    endtask

    // Advance one clock; returns just after the falling edge with inputs settled
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL reset_ctl got %b exp %b", ctl(), V_IDLE);
        end
        n_tests++;
        if (bus.bus_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus_err got %b exp 0", bus.bus_err_out);
        end
        n_tests++;
        if (bus.stall_cycles_out !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt got %0d exp 0", bus.stall_cycles_out);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        bus.ex_is_load_in   = 1'b1;
        bus.ex_rf_wr_en_in  = 1'b1;
        bus.ex_rd_addr_in   = 5'd5;
        bus.dec_rs1_addr_in = 5'd5;
        bus.dec_rs1_used_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_LU) begin
            n_fail++;
            $display("FAIL lu_rs1 got %b exp %b", ctl(), V_LU);
        end
        next_cycle();
        bus.ex_is_load_in  = 1'b0;
        bus.ex_rf_wr_en_in = 1'b0;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL lu_release got %b exp %b", ctl(), V_IDLE);
        end
        next_cycle();
        n_tests++;
        if (bus.stall_cycles_out !== 3'd1) begin
            n_fail++;
            $display("FAIL lu_stall_cnt got %0d exp 1", bus.stall_cycles_out);
        end
        // rs2 dependency
        bus.ex_is_load_in   = 1'b1;
        bus.ex_rf_wr_en_in  = 1'b1;
        bus.ex_rd_addr_in   = 5'd7;
        bus.dec_rs1_used_in = 1'b0;
        bus.dec_rs2_addr_in = 5'd7;
        bus.dec_rs2_used_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_LU) begin
            n_fail++;
            $display("FAIL lu_rs2 got %b exp %b", ctl(), V_LU);
        end
        // matching rs2 that is not read
        bus.dec_rs2_used_in = 1'b0;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL lu_rs2_unused got %b exp %b", ctl(), V_IDLE);
        end
        // load that does not write the RF
        bus.dec_rs2_used_in = 1'b1;
        bus.ex_rf_wr_en_in  = 1'b0;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL lu_no_wr got %b exp %b", ctl(), V_IDLE);
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        apply_reset();
        bus.ex_is_load_in   = 1'b1;
        bus.ex_rf_wr_en_in  = 1'b1;
        bus.ex_rd_addr_in   = 5'd0;
        bus.dec_rs1_addr_in = 5'd0;
        bus.dec_rs1_used_in = 1'b1;
        bus.dec_rs2_addr_in = 5'd0;
        bus.dec_rs2_used_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL x0_ctl got %b exp %b", ctl(), V_IDLE);
        end
        next_cycle();
        n_tests++;
        if (bus.stall_cycles_out !== 3'd0) begin
            n_fail++;
            $display("FAIL x0_stall_cnt got %0d exp 0", bus.stall_cycles_out);
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        apply_reset();
        bus.branch_taken_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_BR) begin
            n_fail++;
            $display("FAIL branch got %b exp %b", ctl(), V_BR);
        end
        bus.ex_is_load_in   = 1'b1;
        bus.ex_rf_wr_en_in  = 1'b1;
        bus.ex_rd_addr_in   = 5'd9;
        bus.dec_rs1_addr_in = 5'd9;
        bus.dec_rs1_used_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_BR) begin
            n_fail++;
            $display("FAIL branch_over_lu got %b exp %b", ctl(), V_BR);
        end
        bus.mret_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_MEPC) begin
            n_fail++;
            $display("FAIL mret_over_branch got %b exp %b", ctl(), V_MEPC);
        end
        bus.dmem_req_in = 1'b1;
        bus.trap_req_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_TRAP) begin
            n_fail++;
            $display("FAIL trap_over_all got %b exp %b", ctl(), V_TRAP);
        end
        bus.dmem_req_in = 1'b0;
        bus.mret_in     = 1'b0;
        bus.ex_is_load_in = 1'b0;
        next_cycle();
        // TRAP_ENTER: trap and branch still high are ignored
        n_tests++;
        if (ctl() !== V_TRAP) begin
            n_fail++;
            $display("FAIL trap_enter got %b exp %b", ctl(), V_TRAP);
        end
        idle_inputs();
        next_cycle();
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL after_trap got %b exp %b", ctl(), V_IDLE);
        end
        n_tests++;
        if (bus.stall_cycles_out !== 3'd0) begin
            n_fail++;
            $display("FAIL redirect_stall_cnt got %0d exp 0", bus.stall_cycles_out);
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        bus.dmem_req_in = 1'b1;
        bus.dmem_ack_in = 1'b1;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL zero_wait got %b exp %b", ctl(), V_IDLE);
        end
        next_cycle();
        bus.dmem_ack_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.dmem_ack_in = (c == 3) ? 1'b1 : 1'b0;
            #1;
            n_tests++;
            if (ctl() !== V_MEM) begin
                n_fail++;
                $display("FAIL mem_stall c%0d got %b exp %b", c, ctl(), V_MEM);
            end
            next_cycle();
            bus.dmem_req_in = 1'b0;
        end
        idle_inputs();
        #1;
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL mem_done got %b exp %b", ctl(), V_IDLE);
        end
        n_tests++;
        if (bus.stall_cycles_out !== 3'd4) begin
            n_fail++;
            $display("FAIL mem_stall_cnt got %0d exp 4", bus.stall_cycles_out);
        end
    endtask

    task automatic test_mem_trap();
        apply_reset();
        bus.dmem_req_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.trap_req_in = (c == 2) ? 1'b1 : 1'b0;
            bus.dmem_ack_in = (c == 4) ? 1'b1 : 1'b0;
            #1;
            n_tests++;
            if (ctl() !== V_MEM) begin
                n_fail++;
                $display("FAIL memtrap_wait c%0d got %b exp %b", c, ctl(), V_MEM);
            end
            next_cycle();
            bus.dmem_req_in = 1'b0;
        end
        idle_inputs();
        #1;
        n_tests++;
        if (ctl() !== V_TRAP) begin
            n_fail++;
            $display("FAIL memtrap_enter got %b exp %b", ctl(), V_TRAP);
        end
        next_cycle();
        n_tests++;
        if (ctl() !== V_IDLE) begin
            n_fail++;
            $display("FAIL memtrap_run got %b exp %b", ctl(), V_IDLE);
        end
        n_tests++;
        if (bus.stall_cycles_out !== 3'd5) begin
            n_fail++;
            $display("FAIL memtrap_stall_cnt got %0d exp 5", bus.stall_cycles_out);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        bus.dmem_req_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (ctl() !== V_MEM || bus.bus_err_out !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_wait c%0d got %b/%b exp %b/0", c, ctl(), bus.bus_err_out, V_MEM);
            end
            next_cycle();
            bus.dmem_req_in = 1'b0;
        end
        n_tests++;
        if (ctl() !== V_TRAP || bus.bus_err_out !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_trap got %b/%b exp %b/1", ctl(), bus.bus_err_out, V_TRAP);
        end
        next_cycle();
        n_tests++;
        if (ctl() !== V_IDLE || bus.bus_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_after got %b/%b exp %b/0", ctl(), bus.bus_err_out, V_IDLE);
        end
        n_tests++;
        if (bus.stall_cycles_out !== 3'd5) begin
            n_fail++;
            $display("FAIL tmo_stall_cnt got %0d exp 5", bus.stall_cycles_out);
        end
        // reset in the middle of a wait with a trap pending
        bus.dmem_req_in = 1'b1;
        next_cycle();
        bus.dmem_req_in = 1'b0;
        bus.trap_req_in = 1'b1;
        next_cycle();
        bus.trap_req_in = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ctl() !== V_IDLE || bus.stall_cycles_out !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_midwait got %b/%0d exp %b/0", ctl(), bus.stall_cycles_out, V_IDLE);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        n_tests++;
        if (ctl() !== V_IDLE || bus.bus_err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_pending got %b/%b exp %b/0", ctl(), bus.bus_err_out, V_IDLE);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        bus.ex_is_load_in   = 1'b1;
        bus.ex_rf_wr_en_in  = 1'b1;
        bus.ex_rd_addr_in   = 5'd3;
        bus.dec_rs1_addr_in = 5'd3;
        bus.dec_rs1_used_in = 1'b1;
        for (int c = 0; c < 6; c++) next_cycle();
        n_tests++;
        if (bus.stall_cycles_out !== 3'd6) begin
            n_fail++;
            $display("FAIL sat_mid got %0d exp 6", bus.stall_cycles_out);
        end
        for (int c = 0; c < 3; c++) next_cycle();
        n_tests++;
        if (bus.stall_cycles_out !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_hold got %0d exp 7", bus.stall_cycles_out);
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_x0();
        test_redirect();
        test_mem_wait();
        test_mem_trap();
        test_timeout();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
